gates_logic_unit: RTL and testbench

//  Parametrised, pipelined successor to the basic two-input gate set. Applies one of

---
 rtl/gates_logic_unit.sv | 142 ++++++++++++++
 tb/tb_gates_logic_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gates_logic_unit.sv
// gates_logic_unit: two-stage pipelined bitwise gate unit with valid/ready handshakes.
// Stage 1 captures op/a/b. Stage 2 holds the computed result, which drives out_data.
// Optional feature macro: GATES_LU_FLAGS_EN. When it is defined, {parity, all_ones, zero}
// flags are registered alongside the result. When it is undefined, out_flags reads 3'b000.
`timescale 1ns/1ps

module gates_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_flags
);

  // Bitwise gate evaluation. NOT and BUF use only operand a.
  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       f_op,
                                                 input logic [WIDTH-1:0] f_a,
                                                 input logic [WIDTH-1:0] f_b);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    case (f_op)
      3'd0:    r = f_a & f_b;
      3'd1:    r = f_a | f_b;
      3'd2:    r = ~f_a;
      3'd3:    r = ~(f_a & f_b);
      3'd4:    r = ~(f_a | f_b);
      3'd5:    r = f_a ^ f_b;
      3'd6:    r = ~(f_a ^ f_b);
      3'd7:    r = f_a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

`ifdef GATES_LU_FLAGS_EN
  // Result flags: {even/odd parity, all ones, zero}.
  function automatic logic [2:0] flags_eval(input logic [WIDTH-1:0] r);
    return {^r, &r, ~|r};
  endfunction
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
`ifdef GATES_LU_FLAGS_EN
  logic [2:0]       s2_flags_q, s2_flags_d;
`endif

  logic s2_adv;
  logic s1_adv;

  // A stage may advance when it is empty or the stage downstream of it is moving.
  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Next-state logic for both pipeline stages. Each stage holds its value unless it advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
`ifdef GATES_LU_FLAGS_EN
    s2_flags_d = s2_flags_q;
`endif

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = gate_eval(s1_op_q, s1_a_q, s1_b_q);
`ifdef GATES_LU_FLAGS_EN
        s2_flags_d = flags_eval(gate_eval(s1_op_q, s1_a_q, s1_b_q));
`endif
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_a_d  = a;
        s1_b_d  = b;
      end else begin
        s1_op_d = s1_op_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers. The asynchronous reset discards all in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 3'd0;
      s1_a_q     <= {WIDTH{1'b0}};
      s1_b_q     <= {WIDTH{1'b0}};
      s2_valid_q <= 1'b0;
      s2_data_q  <= {WIDTH{1'b0}};
`ifdef GATES_LU_FLAGS_EN
      s2_flags_q <= 3'b000;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
`ifdef GATES_LU_FLAGS_EN
      s2_flags_q <= s2_flags_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
`ifdef GATES_LU_FLAGS_EN
  assign out_flags = s2_flags_q;
`else
  assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_gates_logic_unit.sv
// Testbench for gates_logic_unit (WIDTH=8). Directed scenarios are combined with random traffic.
// All traffic is scored against a queue-based reference of accepted beats.
`timescale 1ns/1ps

module tb_gates_logic_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_flags;

  gates_logic_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    int         acc;
  } beat_t;

  beat_t      sb[$];
  int         cyc;
  int         n_checks;
  int         n_errors;
  logic       stalled_prev;
  logic [7:0] held_data;
  logic       took;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference for the gate set, taken from the operation table.
  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return 8'hFF - x;
      3'd3:    return 8'hFF - (x & y);
      3'd4:    return 8'hFF - (x | y);
      3'd5:    return x ^ y;
      3'd6:    return 8'hFF - (x ^ y);
      default: return x;
    endcase
  endfunction

  // Reference for the flags: parity, all ones, zero (all zero in a build without flags).
  function automatic logic [2:0] ref_flags(input logic [7:0] r);
`ifdef GATES_LU_FLAGS_EN
    return {($countones(r) % 2 == 1), (r == 8'hFF), (r == 8'h00)};
`else
    return 3'b000 & {3{r[0]}};
`endif
  endfunction

  // One clock cycle. Inputs are driven after the rising edge, checks run at the falling edge,
  // and the model is updated at the next rising edge.
  task automatic step(input logic iv, input logic [2:0] op_i, input logic [7:0] a_i,
                      input logic [7:0] b_i, input logic ordy, output logic took_o);
    logic exp_valid;
    logic gave;
    beat_t nb;
    in_valid  = iv;
    op        = op_i;
    a         = a_i;
    b         = b_i;
    out_ready = ordy;
    @(negedge clk);
    check_val("in_ready", 32'(in_ready), (sb.size() == 2 && !ordy) ? 32'd0 : 32'd1);
    exp_valid = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
    check_val("out_valid", 32'(out_valid), 32'(exp_valid));
    if (out_valid && sb.size() > 0) begin
      check_val("out_data", 32'(out_data), 32'(sb[0].res));
      check_val("out_flags", 32'(out_flags), 32'(ref_flags(sb[0].res)));
    end
    if (stalled_prev) begin
      check_val("stall_hold", 32'(out_data), 32'(held_data));
    end
    stalled_prev = out_valid && !ordy;
    held_data    = out_data;
    took_o       = iv && in_ready;
    gave         = out_valid && ordy;
    @(posedge clk);
    if (gave && sb.size() > 0) begin
      void'(sb.pop_front());
    end
    if (took_o) begin
      nb.res = ref_op(op_i, a_i, b_i);
      nb.acc = cyc;
      sb.push_back(nb);
    end
    cyc++;
    #1;
  endtask

  // Holds reset for three cycles with in_valid high, checks the reset state, then releases.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      check_val("rst_out_flags", 32'(out_flags), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
    end
    sb.delete();
    stalled_prev = 1'b0;
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [7:0] beats_a [4];
    int         idx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b0;
    cyc       = 0;
    n_checks  = 0;
    n_errors  = 0;
    stalled_prev = 1'b0;
    held_data = 8'h00;

    do_reset();

    // First beat after reset: no result until two cycles after it is accepted.
    step(1'b1, 3'd5, 8'h5A, 8'h0F, 1'b1, took);
    check_val("first_accept", 32'(took), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, took);

    // All eight ops applied back-to-back to a=C5, b=3A.
    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 8'hC5, 8'h3A, 1'b1, took);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, took);

    // Back-pressure: four beats with out_ready held low for five cycles, then released.
    beats_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(idx < 4, 3'd1, beats_a[idx % 4], 8'h80, 1'b0, took);
      if (took) idx++;
    end
    check_val("bp_accepted", 32'(idx), 32'd2);
    for (int i = 0; i < 8; i++) begin
      step(idx < 4, 3'd1, beats_a[idx % 4], 8'h80, 1'b1, took);
      if (took) idx++;
    end
    check_val("bp_all_accepted", 32'(idx), 32'd4);
    check_val("bp_drained", 32'(sb.size()), 32'd0);

    // Simultaneous transfer in and out on a full pipe.
    step(1'b1, 3'd0, 8'hF0, 8'h0F, 1'b0, took);
    step(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b0, took);
    check_val("full_occ", 32'(sb.size()), 32'd2);
    step(1'b1, 3'd7, 8'h07, 8'h00, 1'b1, took);
    check_val("simul_in", 32'(took), 32'd1);
    check_val("simul_occ", 32'(sb.size()), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, took);

    // Reset mid-stream with two beats in flight.
    step(1'b1, 3'd5, 8'hAA, 8'h0F, 1'b0, took);
    step(1'b1, 3'd6, 8'hAA, 8'h0F, 1'b0, took);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, took);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_drop", 32'(out_valid), 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, took);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 7), took);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, took);
    check_val("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
